uart_tx_engine: RTL and testbench

//  Serialiser stage directly downstream of a channel's TX FIFO. Pops bytes from the FIFO,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_cnt.sv | 31 +++
 rtl/uart_tx_engine.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_e          serialiser FSM state encoding
//   UART_IDLE_LVL       line level while no frame is being sent
//   UART_MAX_DATA_BITS  width of the FIFO data word
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic UART_IDLE_LVL      = 1'b1;
   localparam int   UART_MAX_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down-counter for the UART serialiser.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, clears the count
//   load     reload with div-1 (start of a new bit period)
//   div      cycles per bit, must be >= 1 when load is asserted
//   bit_end  high while the count is 0, i.e. in the last cycle of a bit
module uart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= div - DIV_W'(1);
      else if (count != '0)
         count <= count - DIV_W'(1);
   end

   assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: pops bytes from a first-word-fall-through TX FIFO and
// serialises them as start, LSB-first data, optional parity and stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tx_en           new frames start only while high
//   baud_div        clk cycles per bit (0 behaves as 1), sampled per frame
//   cfg_parity_odd  1 = odd, 0 = even parity, sampled per frame
//   fifo_empty      FIFO empty flag
//   fifo_data       FIFO head byte, valid while !fifo_empty
//   fifo_rd         one-cycle pop strobe
//   uart_txd        serial line, idle high
//   tx_busy         high from the pop cycle through the last stop cycle
//   tx_done         pulse in the last cycle of each frame
//
// state  | meaning
// IDLE   | line idle, waiting for tx_en and a byte
// START  | driving the start bit (0)
// DATA   | driving data bit bit_idx, LSB first
// PARITY | driving the parity bit (parity builds only)
// STOP   | driving stop bit bit_idx, may chain straight into START
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_en,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic                          cfg_parity_odd,
   input  logic                          fifo_empty,
   input  logic [UART_MAX_DATA_BITS-1:0] fifo_data,
   output logic                          fifo_rd,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic                          tx_done
);

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [2:0]           bit_idx_q;
   logic [DIV_W-1:0]     div_q;
   logic [DIV_W-1:0]     div_eff;
   logic [DIV_W-1:0]     cnt_div;
   logic                 can_pop;
   logic                 pop;
   logic                 cnt_load;
   logic                 bit_end;

`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`else
   logic                 unused_cfg_parity_odd;
   assign unused_cfg_parity_odd = cfg_parity_odd;
`endif

   assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
   // rst gates the pop so the FIFO is never touched during reset
   assign can_pop = tx_en && !fifo_empty && !rst;
   // a pop reloads the counter in the same cycle, before div_q is updated
   assign cnt_div = pop ? div_eff : div_q;

   uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .load    (cnt_load),
      .div     (cnt_div),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         div_q     <= '0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (pop) begin
            shift_q <= fifo_data[DATA_BITS-1:0];
            div_q   <= div_eff;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^fifo_data[DATA_BITS-1:0]) ^ cfg_parity_odd;
`endif
         end else if (state_q == DATA && bit_end) begin
            shift_q <= shift_q >> 1;
         end
         // bit_idx counts bits within DATA and within STOP; any state change restarts it
         if (cnt_load)
            bit_idx_q <= (state_d == state_q) ? bit_idx_q + 3'd1 : 3'd0;
      end
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      cnt_load = 1'b0;
      uart_txd = UART_IDLE_LVL;
      tx_busy  = 1'b1;
      tx_done  = 1'b0;
      unique case (state_q)
         IDLE: begin
            tx_busy = can_pop;
            if (can_pop) begin
               pop      = 1'b1;
               cnt_load = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            uart_txd = 1'b0;
            if (bit_end) begin
               cnt_load = 1'b1;
               state_d  = DATA;
            end
         end
         DATA: begin
            uart_txd = shift_q[0];
            if (bit_end) begin
               cnt_load = 1'b1;
               if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            uart_txd = par_q;
            if (bit_end) begin
               cnt_load = 1'b1;
               state_d  = STOP;
            end
         end
`endif
         STOP: begin
            uart_txd = 1'b1;
            if (bit_end) begin
               if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                  tx_done = 1'b1;
                  if (can_pop) begin
                     pop      = 1'b1;
                     cnt_load = 1'b1;
                     state_d  = START;
                  end else begin
                     state_d  = IDLE;
                  end
               end else begin
                  cnt_load = 1'b1;
               end
            end
         end
         default: begin
            tx_busy = 1'b0;
            state_d = IDLE;
         end
      endcase
      fifo_rd = pop;
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized and directed stimulus for uart_tx_engine,
// checked cycle by cycle against a frame-level reference model (a queue of
// expected line levels built from each popped byte).
module tb_uart_tx_engine;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int DIV_W     = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS  = 1;
`else
   localparam int PAR_BITS  = 0;
`endif
   localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tx_en = 1'b0;
   logic [DIV_W-1:0] baud_div = '0;
   logic             cfg_parity_odd = 1'b0;
   logic             fifo_empty = 1'b1;
   logic [7:0]       fifo_data = '0;
   logic             fifo_rd;
   logic             uart_txd;
   logic             tx_busy;
   logic             tx_done;

   always #5 clk = ~clk;

   uart_tx_engine #(
      .DATA_BITS (DATA_BITS),
      .STOP_BITS (STOP_BITS),
      .DIV_W     (DIV_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .tx_en          (tx_en),
      .baud_div       (baud_div),
      .cfg_parity_odd (cfg_parity_odd),
      .fifo_empty     (fifo_empty),
      .fifo_data      (fifo_data),
      .fifo_rd        (fifo_rd),
      .uart_txd       (uart_txd),
      .tx_busy        (tx_busy),
      .tx_done        (tx_done)
   );

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [7:0]       fq[$];
   logic             exp_q[$];
   logic             rst_v = 1'b1;
   logic             en_v  = 1'b0;
   logic             odd_v = 1'b0;
   logic [DIV_W-1:0] div_v = '0;
   logic             rd_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // expected line levels of one frame, each repeated div cycles
   function automatic void add_frame(input logic [7:0] b, input int div, input logic odd);
      logic lv[$];
      int   ones = 0;
      lv.push_back(1'b0);
      for (int i = 0; i < DATA_BITS; i++) begin
         lv.push_back(b[i]);
         ones += int'(b[i]);
      end
      if (PAR_BITS == 1)
         lv.push_back(((ones % 2) == 1) ^ odd);
      for (int i = 0; i < STOP_BITS; i++)
         lv.push_back(1'b1);
      foreach (lv[i])
         for (int k = 0; k < div; k++)
            exp_q.push_back(lv[i]);
   endfunction

   task automatic eval();
      logic et, ed, eb, er;
      if (rst) begin
         exp_q.delete();
         check("rd_in_rst", fifo_rd, 1'b0);
         rd_prev = fifo_rd;
         return;
      end
      er = (exp_q.size() <= 1) && tx_en && !fifo_empty;
      if (exp_q.size() > 0) begin
         et = exp_q.pop_front();
         ed = (exp_q.size() == 0);
         eb = 1'b1;
      end else begin
         et = 1'b1;
         ed = 1'b0;
         eb = er;
      end
      check("txd", uart_txd, et);
      check("fifo_rd", fifo_rd, er);
      check("tx_done", tx_done, ed);
      check("tx_busy", tx_busy, eb);
      if (er)
         add_frame(fifo_data, (baud_div == '0) ? 1 : int'(baud_div), cfg_parity_odd);
      rd_prev = fifo_rd;
   endtask

   task automatic tick();
      logic [7:0] junk;
      @(posedge clk);
      #1;
      if (rd_prev && fq.size() > 0)
         junk = fq.pop_front();
      rst            = rst_v;
      tx_en          = en_v;
      baud_div       = div_v;
      cfg_parity_odd = odd_v;
      fifo_empty     = (fq.size() == 0);
      fifo_data      = fifo_empty ? 8'($urandom) : fq[0];
      @(negedge clk);
      eval();
   endtask

   // runs until tx_done; len counts cycles after the pop through tx_done
   task automatic frame_wait(input int budget, output int len, output int pops);
      logic started = 1'b0;
      len  = 0;
      pops = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (started) len++;
         if (fifo_rd) pops++;
         if (fifo_rd && !started) started = 1'b1;
         if (tx_done) return;
      end
      check("frame_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_pop(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (fifo_rd) return;
      end
      check("pop_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int budget);
      en_v = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (fq.size() == 0 && exp_q.size() == 0 && !tx_busy) return;
      end
      check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, pops;

      repeat (3) tick();
      rst_v = 1'b0;
      tick();
      check("rst_txd", uart_txd, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_rd", fifo_rd, 1'b0);

      // single byte, div 4
      div_v = 16'd4; en_v = 1'b1; odd_v = 1'b0;
      fq.push_back(8'h55);
      frame_wait(200, len, pops);
      check("t1_len", len, FRAME_BITS * 4);
      check("t1_pops", pops, 1);
      tick();
      check("t1_busy_after", tx_busy, 1'b0);

      // back-to-back frames, div 2
      div_v = 16'd2;
      fq.push_back(8'hA5);
      fq.push_back(8'h3C);
      frame_wait(200, len, pops);
      check("t2_rd_at_done", fifo_rd, 1'b1);
      tick();
      check("t2_no_gap", uart_txd, 1'b0);
      drain(200);

      // empty FIFO while enabled
      pops = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (fifo_rd) pops++;
      end
      check("t3_pops", pops, 0);
      check("t3_txd", uart_txd, 1'b1);

      // reset in the middle of a frame
      div_v = 16'd4;
      fq.push_back(8'h00);
      wait_pop(20);
      repeat (10) tick();
      rst_v = 1'b1;
      tick();
      rst_v = 1'b0;
      tick();
      check("t4_txd", uart_txd, 1'b1);
      check("t4_busy", tx_busy, 1'b0);
      fq.push_back(8'h00);
      frame_wait(200, len, pops);
      check("t4_fresh_len", len, FRAME_BITS * 4);

      // div 0 behaves as 1; tx_en dropped during data
      div_v = '0;
      fq.push_back(8'hFF);
      fq.push_back(8'hFF);
      wait_pop(20);
      repeat (3) tick();
      en_v = 1'b0;
      pops = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (fifo_rd) pops++;
      end
      check("t5_pops", pops, 0);
      check("t5_left", fq.size(), 1);
      drain(100);

      // parity sense (frame is 11 bits when parity is built in)
      div_v = 16'd1; en_v = 1'b1;
      odd_v = 1'b0;
      fq.push_back(8'h07);
      frame_wait(100, len, pops);
      check("t6_even_len", len, FRAME_BITS);
      odd_v = 1'b1;
      fq.push_back(8'h07);
      frame_wait(100, len, pops);
      check("t6_odd_len", len, FRAME_BITS);
      drain(100);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0 && fq.size() < 4)
            fq.push_back(8'($urandom));
         if ($urandom_range(0, 19) == 0)
            en_v = ~en_v;
         if ($urandom_range(0, 29) == 0)
            div_v = DIV_W'($urandom_range(0, 4));
         if ($urandom_range(0, 29) == 0)
            odd_v = 1'($urandom);
         tick();
      end
      drain(2000);
      check("end_fifo_empty", fq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
